pwm_rgb_level_decoder: RTL and testbench
========================================

Name: pwm_rgb_level_decoder

Overview:
- Receive-side counterpart of the team's RGB PWM LED driver.
- Observes the three 4-bit PWM channel buses (each driven 4'b1111 or 4'b0000, period 100 clocks) and recovers each channel's 2-bit intensity code (0/33/66/100 % duty).
- Used for loopback self-check of the LED path and for feeding LED state back to the status/control logic.

Parameters:
- PERIOD, 100, measurement window length in CLK cycles (equals the PWM period).
- CW, 7, width of the window and high-time counters (must satisfy 2^CW > PERIOD).
- TH1, 17, minimum high count decoded as code 01.
- TH2, 50, minimum high count decoded as code 10.
- TH3, 84, minimum high count decoded as code 11.

Ports:
- CLK  in  1  system clock
- RESETN  in  1  asynchronous reset, active-high
- EN  in  1  decode enable
- R_PWM  in  4  red PWM bus
- G_PWM  in  4  green PWM bus
- B_PWM  in  4  blue PWM bus
- CLR_ERR  in  1  clears the sticky ERR flag
- R_OUT  out  2  decoded red code
- G_OUT  out  2  decoded green code
- B_OUT  out  2  decoded blue code
- VALID  out  1  one-cycle pulse at the end of each window
- CHG  out  1  one-cycle pulse, coincident with VALID, when any output code changed
- ERR  out  1  sticky flag for a malformed bus sample

Behaviour:
- Reset: RESETN high clears all state asynchronously. R_OUT, G_OUT, B_OUT = 2'b00; VALID, CHG, ERR = 0; all counters and the sample register = 0.
- Input stage: all three buses are registered once per clock (sample register S). A channel counts as "high" when its S value = 4'b1111. Any other value counts as low.
- Window counter WCNT:
  - Runs 0..PERIOD-1 and wraps to 0 while EN = 1.
  - Per channel, HCNT increments when that channel's S is high.
- End of window (edge at which WCNT = PERIOD-1):
  - total = HCNT + (S high ? 1 : 0).
  - Code: total < TH1 → 00; < TH2 → 01; < TH3 → 10; otherwise 11.
  - The code is registered into the *_OUT register at that edge.
  - HCNT resets to 0 and WCNT wraps to 0.
- VALID goes to 1 on the same edge that updates the outputs and stays high exactly one cycle, once per PERIOD cycles.
- CHG = 1 in that same cycle only if at least one of R_OUT/G_OUT/B_OUT differs from its previous value.
- Window phase is free-running: it does not need to align with the PWM phase. For a steady periodic input, any PERIOD-length window yields the exact duty count.
- EN low:
  - WCNT and HCNT are held at 0; VALID and CHG stay 0; *_OUT hold their values.
  - When EN returns high, a fresh full window starts, so the first VALID follows PERIOD cycles later.
- ERR:
  - Set on the edge after any channel's S is neither 4'b0000 nor 4'b1111.
  - Sticky until CLR_ERR = 1 at a clock edge.
  - If a set condition and CLR_ERR occur on the same edge, the set wins.
  - ERR is independent of EN.
- Boundaries:
  - 0% duty gives total 0 → code 00.
  - 100% duty gives total PERIOD → code 11. The counter does not overflow because 2^CW > PERIOD.
  - Reset asserted mid-window discards the partial count. After release, the first window starts at WCNT = 0.

Optional Feature:
- Macro: PWM_DEC_STABLE_EN.
- Defined: each channel keeps the code from the previous window.
  - *_OUT updates only when the current window's code equals the previous window's code (two consecutive matching windows).
  - VALID still pulses every window.
  - CHG pulses only when an output actually changes.
  - The previous-window codes reset to 00.
- Undefined: outputs update from every window's code, as described in Behaviour.

Test Plan:
- Drive steady PWM: R 33%, G 66%, B 100% (period 100, EN = 1) → after the first full window R_OUT = 01, G_OUT = 10, B_OUT = 11; VALID pulses every 100 cycles; CHG = 1 on the first VALID only.
- Threshold sweep with a single-window constant high count on R → 16 gives 00, 17 gives 01, 49 gives 01, 50 gives 10, 83 gives 10, 84 gives 11.
- All buses 4'b0000 for 300 cycles → all outputs 00, CHG never pulses. Then all buses 4'b1111 → outputs 11 after the next complete window, CHG pulses once.
- R_PWM = 4'b0101 for one cycle → ERR = 1 two edges later and holds. CLR_ERR pulse → ERR = 0. CLR_ERR asserted together with another 4'b0011 sample → ERR stays 1.
- EN low at WCNT = 40 for 30 cycles, then high → no VALID while EN is low; next VALID exactly 100 cycles after EN rises; outputs unchanged while EN is low. RESETN pulse at WCNT = 60 → all outputs 0 immediately; next VALID 101 cycles after reset release (includes the input-stage cycle).
- Change R from 33% to 66% at an arbitrary phase → without PWM_DEC_STABLE_EN, the first straddling window may produce 01 or 10 before settling at 10. With the macro defined, R_OUT goes 01 → 10 only after two consecutive windows decode 10.

Source files
------------

// File: rtl/pwm_rgb_level_decoder.sv
// Recovers 2-bit intensity codes from three PWM LED buses by windowed high-time counting.
// Optional `PWM_DEC_STABLE_EN: outputs update only after two consecutive matching windows.
module pwm_rgb_level_decoder #(
  parameter int PERIOD = 100,
  parameter int CW     = 7,
  parameter int TH1    = 17,
  parameter int TH2    = 50,
  parameter int TH3    = 84
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       EN,
  input  logic [3:0] R_PWM,
  input  logic [3:0] G_PWM,
  input  logic [3:0] B_PWM,
  input  logic       CLR_ERR,
  output logic [1:0] R_OUT,
  output logic [1:0] G_OUT,
  output logic [1:0] B_OUT,
  output logic       VALID,
  output logic       CHG,
  output logic       ERR
);

  logic [2:0][3:0]    s_q, s_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [2:0][CW-1:0] hcnt_q, hcnt_d;
  logic [2:0][1:0]    out_q, out_d;
  logic               valid_q, valid_d;
  logic               chg_q, chg_d;
  logic               err_q, err_d;
`ifdef PWM_DEC_STABLE_EN
  logic [2:0][1:0]    prv_q, prv_d;
`endif

  logic [2:0]         hi;
  logic               bad;
  logic               wend;
  logic [2:0][CW-1:0] tot;
  logic [2:0][1:0]    code;

  function automatic logic [1:0] lvl(input logic [CW-1:0] t);
    logic [1:0] c;
    if (t < CW'(TH1))      c = 2'b00;
    else if (t < CW'(TH2)) c = 2'b01;
    else if (t < CW'(TH3)) c = 2'b10;
    else                   c = 2'b11;
    return c;
  endfunction

  // Sample, count high time per window and decode codes at window end
  always_comb begin
    s_d    = {B_PWM, G_PWM, R_PWM};
    hi     = '0;
    bad    = 1'b0;
    tot    = '0;
    code   = '0;
    hcnt_d = '0;
    out_d  = out_q;
`ifdef PWM_DEC_STABLE_EN
    prv_d  = prv_q;
`endif
    wend   = EN && (wcnt_q == CW'(PERIOD - 1));
    wcnt_d = '0;
    if (EN && !wend) wcnt_d = wcnt_q + 1'b1;
    for (int i = 0; i < 3; i++) begin
      hi[i]   = (s_q[i] == 4'hF);
      bad     = bad | ((s_q[i] != 4'hF) && (s_q[i] != 4'h0));
      tot[i]  = hcnt_q[i] + CW'(hi[i]);
      code[i] = lvl(tot[i]);
      if (EN && !wend) hcnt_d[i] = tot[i];
      if (wend) begin
`ifdef PWM_DEC_STABLE_EN
        if (code[i] == prv_q[i]) out_d[i] = code[i];
        prv_d[i] = code[i];
`else
        out_d[i] = code[i];
`endif
      end
    end
    valid_d = wend;
    chg_d   = wend && (out_d != out_q);
    err_d   = bad ? 1'b1 : (CLR_ERR ? 1'b0 : err_q);
  end

  // State registers, cleared asynchronously by RESETN high
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      s_q     <= '0;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PWM_DEC_STABLE_EN
      prv_q   <= '0;
`endif
    end else begin
      s_q     <= s_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
`ifdef PWM_DEC_STABLE_EN
      prv_q   <= prv_d;
`endif
    end
  end

  assign R_OUT = out_q[0];
  assign G_OUT = out_q[1];
  assign B_OUT = out_q[2];
  assign VALID = valid_q;
  assign CHG   = chg_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_pwm_rgb_level_decoder.sv
// Scoreboard bench for pwm_rgb_level_decoder: window-aligned PWM stimulus,
// expected codes queued per window and checked whenever VALID pulses.
module tb_pwm_rgb_level_decoder;

  logic       CLK = 1'b0;
  logic       RESETN, EN, CLR_ERR;
  logic [3:0] R_PWM, G_PWM, B_PWM;
  logic [1:0] R_OUT, G_OUT, B_OUT;
  logic       VALID, CHG, ERR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] r, g, b;
    logic       chg;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [1:0] eo[3];
  logic [1:0] ep[3];

  pwm_rgb_level_decoder dut (
    .CLK(CLK), .RESETN(RESETN), .EN(EN),
    .R_PWM(R_PWM), .G_PWM(G_PWM), .B_PWM(B_PWM),
    .CLR_ERR(CLR_ERR),
    .R_OUT(R_OUT), .G_OUT(G_OUT), .B_OUT(B_OUT),
    .VALID(VALID), .CHG(CHG), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int dr, dg, db, input int p);
    R_PWM = (p < dr) ? 4'hF : 4'h0;
    G_PWM = (p < dg) ? 4'hF : 4'h0;
    B_PWM = (p < db) ? 4'hF : 4'h0;
  endtask

  // Queue the expected result of the window about to be driven
  task automatic push(input logic [1:0] cr, cg, cb);
    logic [1:0] c[3];
    logic [1:0] n;
    logic       ch;
    exp_t       e;
    c  = '{cr, cg, cb};
    ch = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef PWM_DEC_STABLE_EN
      n = (c[i] == ep[i]) ? c[i] : eo[i];
`else
      n = c[i];
`endif
      ch    = ch | (n != eo[i]);
      eo[i] = n;
      ep[i] = c[i];
    end
    e.r   = eo[0];
    e.g   = eo[1];
    e.b   = eo[2];
    e.chg = ch;
    e.cyc = cyc + 101;
    q.push_back(e);
  endtask

  // One full window; sample p=0 is taken on the edge before the window's first count
  task automatic run_win(input int dr, dg, db,
                         input logic [1:0] cr, cg, cb, input bit rel);
    push(cr, cg, cb);
    for (int p = 0; p < 100; p++) begin
      if (p == 1) EN = 1'b1;
      drive(dr, dg, db, p);
      step();
      if (rel && p == 0) RESETN = 1'b0;
    end
  endtask

  task automatic run_part(input int dr, dg, db, input int n);
    for (int p = 0; p < n; p++) begin
      drive(dr, dg, db, p);
      step();
    end
  endtask

  // Monitor: pop and compare on every VALID pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (VALID) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL valid_unexp cyc=%0d act=1 exp=0", cyc);
        end else begin
          e = q.pop_front();
          chk("r_out", R_OUT, e.r);
          chk("g_out", G_OUT, e.g);
          chk("b_out", B_OUT, e.b);
          chk("chg", CHG, e.chg);
          chk("valid_cyc", cyc, e.cyc);
        end
      end else if (CHG) begin
        total++;
        bad++;
        $display("FAIL chg_stray cyc=%0d act=1 exp=0", cyc);
      end
    end
  end

  initial begin
    RESETN  = 1'b1;
    EN      = 1'b1;
    CLR_ERR = 1'b0;
    R_PWM   = 4'h0;
    G_PWM   = 4'h0;
    B_PWM   = 4'h0;
    eo      = '{2'b00, 2'b00, 2'b00};
    ep      = '{2'b00, 2'b00, 2'b00};
    repeat (3) step();
    chk("rst_r", R_OUT, 0);
    chk("rst_g", G_OUT, 0);
    chk("rst_b", B_OUT, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_chg", CHG, 0);
    chk("rst_err", ERR, 0);

    // Steady 33/66/100; first window loses the sample taken in reset
    run_win(33, 66, 100, 2'b01, 2'b10, 2'b11, 1'b1);
    run_win(33, 66, 100, 2'b01, 2'b10, 2'b11, 1'b0);
    run_win(33, 66, 100, 2'b01, 2'b10, 2'b11, 1'b0);

    // Threshold sweep on red
    run_win(16, 66, 100, 2'b00, 2'b10, 2'b11, 1'b0);
    run_win(17, 66, 100, 2'b01, 2'b10, 2'b11, 1'b0);
    run_win(49, 66, 100, 2'b01, 2'b10, 2'b11, 1'b0);
    run_win(50, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);
    run_win(83, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);
    run_win(84, 66, 100, 2'b11, 2'b10, 2'b11, 1'b0);

    // All off for 300 cycles, then all on
    run_win(0, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0);
    run_win(0, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0);
    run_win(0, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0);
    run_win(100, 100, 100, 2'b11, 2'b11, 2'b11, 1'b0);
    run_win(100, 100, 100, 2'b11, 2'b11, 2'b11, 1'b0);

    // Red 33% -> 66%
    run_win(33, 66, 100, 2'b01, 2'b10, 2'b11, 1'b0);
    run_win(66, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);
    run_win(66, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);

    // EN drops at WCNT=40 for 30 cycles; ERR exercised meanwhile
    run_part(66, 66, 100, 41);
    EN    = 1'b0;
    R_PWM = 4'h0;
    G_PWM = 4'h0;
    B_PWM = 4'h0;
    R_PWM = 4'h5;
    step();
    chk("err_lat", ERR, 0);
    R_PWM = 4'h0;
    step();
    chk("err_set", ERR, 1);
    step();
    chk("err_hold", ERR, 1);
    CLR_ERR = 1'b1;
    step();
    chk("err_clr", ERR, 0);
    CLR_ERR = 1'b0;
    R_PWM   = 4'h3;
    step();
    CLR_ERR = 1'b1;
    R_PWM   = 4'h0;
    step();
    chk("err_set_wins", ERR, 1);
    step();
    chk("err_clr2", ERR, 0);
    CLR_ERR = 1'b0;
    repeat (21) step();
    chk("en_hold_r", R_OUT, eo[0]);
    chk("en_hold_g", G_OUT, eo[1]);
    chk("en_hold_b", B_OUT, eo[2]);
    run_win(66, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);
    run_win(66, 66, 100, 2'b10, 2'b10, 2'b11, 1'b0);

    // Reset at WCNT=60 discards the partial window
    run_part(66, 66, 100, 61);
    RESETN = 1'b1;
    #1;
    chk("mid_rst_r", R_OUT, 0);
    chk("mid_rst_g", G_OUT, 0);
    chk("mid_rst_b", B_OUT, 0);
    chk("mid_rst_valid", VALID, 0);
    eo = '{2'b00, 2'b00, 2'b00};
    ep = '{2'b00, 2'b00, 2'b00};
    run_win(33, 0, 100, 2'b01, 2'b00, 2'b11, 1'b1);
    run_win(33, 0, 100, 2'b01, 2'b00, 2'b11, 1'b0);

    repeat (5) step();
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
